// File: rtl/hs_fifo_buf.sv
// rtl/hs_fifo_buf.sv - registered-ready valid/ready FIFO buffer with synchronous flush
// Optional empty bypass enabled by defining HS_FIFO_BUF_BYPASS_EN
module hs_fifo_buf #(
    parameter int DATA_WD = 32,
    parameter int DEPTH = 4,
    localparam int CNT_WD = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic               valid_in,
    input  logic [DATA_WD-1:0] data_in,
    output logic               ready_in,
    output logic               valid_out,
    output logic [DATA_WD-1:0] data_out,
    input  logic               ready_out,
    output logic [CNT_WD-1:0]  count
);

    localparam int PTR_WD = $clog2(DEPTH);

    logic [DATA_WD-1:0] mem [DEPTH];
    logic [PTR_WD-1:0]  wr_ptr;
    logic [PTR_WD-1:0]  rd_ptr;
    logic               ready_in_r;
    logic               fire_in;
    logic               fire_out;
    logic               push;
    logic               pop;
    logic               bypass;
    logic [CNT_WD-1:0]  count_next;

    function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
        return (p == PTR_WD'(DEPTH - 1)) ? '0 : p + PTR_WD'(1);
    endfunction

    assign ready_in = ready_in_r & ~flush;
    assign fire_in  = valid_in & ready_in;
    assign fire_out = valid_out & ready_out;
    assign pop      = fire_out & (count != '0);

`ifdef HS_FIFO_BUF_BYPASS_EN
    // An empty buffer forwards the upstream beat; it is only stored if downstream stalls.
    assign bypass    = (count == '0) & valid_in & ready_out & ~flush;
    assign valid_out = (count != '0) ? ~flush : (valid_in & ~flush);
    assign data_out  = (count != '0) ? mem[rd_ptr] : data_in;
`else
    assign bypass    = 1'b0;
    assign valid_out = (count != '0) & ~flush;
    assign data_out  = mem[rd_ptr];
`endif

    assign push = fire_in & ~bypass;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CNT_WD'(1);
        else if (pop && !push)
            count_next = count - CNT_WD'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ready_in_r <= 1'b0;
        end else begin
            count      <= count_next;
            ready_in_r <= (count_next < CNT_WD'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= ptr_inc(wr_ptr);
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Flush leaves the array untouched; push is already blocked by ready_in during flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_hs_fifo_buf.sv
// tb/tb_hs_fifo_buf.sv - scoreboard bench for hs_fifo_buf (DEPTH 4 directed, DEPTH 3 random)
module tb_hs_fifo_buf;

`ifdef HS_FIFO_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        vin [2];
    logic [31:0] din [2];
    logic        rout [2];
    logic        fl [2];
    logic        rdy [2];
    logic        vo [2];
    logic [31:0] dout [2];
    logic [2:0]  cnt [2];
    logic [1:0]  cnt1_w;

    int          n_pass = 0;
    int          n_total = 0;
    int          m_cnt [2];
    bit          m_rdy [2];
    bit          pending [2];
    logic [31:0] nxt [2];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    hs_fifo_buf #(.DATA_WD(32), .DEPTH(4)) dut0 (
        .clk(clk), .rstn(rstn), .flush(fl[0]), .valid_in(vin[0]), .data_in(din[0]),
        .ready_in(rdy[0]), .valid_out(vo[0]), .data_out(dout[0]), .ready_out(rout[0]),
        .count(cnt[0])
    );

    hs_fifo_buf #(.DATA_WD(32), .DEPTH(3)) dut1 (
        .clk(clk), .rstn(rstn), .flush(fl[1]), .valid_in(vin[1]), .data_in(din[1]),
        .ready_in(rdy[1]), .valid_out(vo[1]), .data_out(dout[1]), .ready_out(rout[1]),
        .count(cnt1_w)
    );

    assign cnt[1] = {1'b0, cnt1_w};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, k, act, exp, $time);
    endtask

    function automatic int dep(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic void q_push(input int k, input logic [31:0] d);
        if (k == 0) q0.push_back(d);
        else q1.push_back(d);
    endfunction

    function automatic logic [31:0] q_pop(input int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void discard(input int k);
        for (int i = 0; i < m_cnt[k]; i++)
            void'(q_pop(k));
        m_cnt[k] = 0;
    endfunction

    // Offering a new beat registers it with the scoreboard; an unaccepted beat is re-offered unchanged.
    task automatic drive(input int k, input bit v, input bit r, input bit f);
        rout[k] = r;
        fl[k] = f;
        if (v && !pending[k]) begin
            pending[k] = 1'b1;
            din[k] = nxt[k];
            nxt[k] = nxt[k] + 32'd1;
            q_push(k, din[k]);
        end
        vin[k] = v;
    endtask

    // Occupancy model: beats held = accepted minus delivered; ready is known one cycle late.
    function automatic void step(input int k);
        bit acc, vout_e, passthru;
        if (!rstn) return;
        acc = vin[k] && m_rdy[k] && !fl[k];
        vout_e = !fl[k] && (m_cnt[k] > 0 || (BYP && vin[k]));
        passthru = BYP && m_cnt[k] == 0 && vin[k] && rout[k] && !fl[k];
        if (fl[k]) begin
            discard(k);
        end else begin
            if (acc && !passthru) m_cnt[k]++;
            if (vout_e && rout[k] && m_cnt[k] > 0 && !(acc && !passthru && m_cnt[k] == 1 && !(m_cnt[k] - 1 > 0)))
                m_cnt[k]--;
        end
        m_rdy[k] = m_cnt[k] < dep(k);
        if (acc) pending[k] = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        step(0);
        step(1);
        #1;
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            for (int k = 0; k < 2; k++) begin
                chk("count", k, cnt[k], m_cnt[k]);
                chk("ready_in", k, rdy[k], m_rdy[k] && !fl[k]);
                chk("valid_out", k, vo[k], !fl[k] && (m_cnt[k] > 0 || (BYP && vin[k])));
                chk("count_bound", k, cnt[k] <= dep(k), 1);
                if (vo[k] && rout[k]) begin
                    if (q_size(k) == 0)
                        chk("spurious_beat", k, dout[k], 64'hdead);
                    else
                        chk("data", k, dout[k], q_pop(k));
                end
            end
        end
    end

    initial begin
        rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vin[k] = 0; din[k] = 0; rout[k] = 0; fl[k] = 0;
            m_cnt[k] = 0; m_rdy[k] = 0; pending[k] = 0; nxt[k] = 32'd1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 0, cnt[0], 0);
        chk("rst_ready", 0, rdy[0], 0);
        chk("rst_valid", 0, vo[0], 0);
        chk("rst_data", 0, dout[0], 0);
        rstn = 1'b1;
        tick();
        chk("ready_after_rst", 0, rdy[0], 1);

        // Streaming: fixed 1-cycle lag (or same-cycle with bypass)
        drive(0, 1, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            drive(0, i < 5, 1, 0);
            @(negedge clk);
            if (i < 5) begin
                chk("stream_count", 0, cnt[0], BYP ? 0 : 1);
                chk("stream_data", 0, dout[0], BYP ? i + 1 : i);
            end
        end
        drive(0, 0, 1, 0);
        repeat (3) tick();

        // Fill to full with downstream stalled
        nxt[0] = 32'hA0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0);
            tick();
        end
        drive(0, 1, 0, 0);
        @(negedge clk);
        chk("full_count", 0, cnt[0], 4);
        chk("full_ready", 0, rdy[0], 0);
        chk("full_valid", 0, vo[0], 1);
        chk("full_data", 0, dout[0], 32'hA0);
        tick();
        drive(0, 1, 1, 0);
        @(negedge clk);
        chk("pop_cycle_count", 0, cnt[0], 4);
        chk("pop_cycle_ready", 0, rdy[0], 0);
        chk("pop_cycle_data", 0, dout[0], 32'hA0);
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("after_pop_count", 0, cnt[0], 3);
        chk("after_pop_ready", 0, rdy[0], 1);
        chk("after_pop_data", 0, dout[0], 32'hA1);
        tick();
        drive(0, 0, 1, 0);
        repeat (5) tick();

        // Flush with two beats held and both sides active
        drive(0, 1, 0, 0);
        tick();
        drive(0, 1, 0, 0);
        tick();
        drive(0, 1, 1, 1);
        @(negedge clk);
        chk("flush_count_before", 0, cnt[0], 2);
        chk("flush_valid", 0, vo[0], 0);
        chk("flush_ready", 0, rdy[0], 0);
        tick();
        drive(0, 1, 1, 0);
        @(negedge clk);
        chk("flush_count_after", 0, cnt[0], 0);
        tick();
        drive(0, 0, 1, 0);
        @(negedge clk);
        chk("post_flush_valid", 0, vo[0], BYP ? 0 : 1);
        chk("post_flush_data", 0, dout[0], 32'hA6);
        repeat (3) tick();

        // Asynchronous reset while holding three beats
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0);
            tick();
        end
        chk("pre_rst_count", 0, cnt[0], 3);
        #2;
        rstn = 1'b0;
        discard(0);
        discard(1);
        m_rdy[0] = 0;
        m_rdy[1] = 0;
        #1;
        chk("async_rst_count", 0, cnt[0], 0);
        chk("async_rst_ready", 0, rdy[0], 0);
        chk("async_rst_valid", 0, vo[0], BYP ? vin[0] : 1'b0);
        vin[0] = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        tick();
        @(negedge clk);
        chk("rel_ready", 0, rdy[0], 1);
        chk("rel_data", 0, dout[0], BYP ? din[0] : 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 0);
            tick();
        end
        drive(0, 0, 1, 0);
        repeat (4) tick();

        // Random traffic on the DEPTH-3 instance, with occasional flushes
        for (int i = 0; i < 10000; i++) begin
            drive(1, ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 97) == 0);
            tick();
        end
        drive(1, 0, 1, 0);
        repeat (6) tick();
        chk("drain0", 0, q_size(0), pending[0] ? 1 : 0);
        chk("drain1", 1, q_size(1), pending[1] ? 1 : 0);
        chk("drain1_count", 1, cnt[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hs_fifo_buf.md
# hs_fifo_buf

Parametrised-depth valid/ready handshake buffer for register-slicing long datapaths between pipeline stages. It holds up to DEPTH beats in a circular store. `ready_in` depends only on registered state, so the combinational ready path between neighbouring stages is broken. It also provides a synchronous flush and an optional empty-bypass mode for zero-latency pass-through.

## Interface
- DATA_WD, 32, payload width in bits
- DEPTH, 4, number of storage entries; legal range 2..256; need not be a power of two
- CNT_WD, $clog2(DEPTH+1), width of `count`; derived, not overridden
- clk  input  1  clock; all state updates on rising edge
- rstn  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all stored beats
- valid_in  input  1  upstream beat valid
- data_in  input  DATA_WD  upstream payload
- ready_in  output  1  buffer can accept a beat
- valid_out  output  1  downstream beat valid
- data_out  output  DATA_WD  downstream payload
- ready_out  input  1  downstream accepts a beat
- count  output  CNT_WD  number of beats currently stored

## Operation
- fire_in = valid_in & ready_in; fire_out = valid_out & ready_out.
- The store is a DEPTH-entry array with write pointer wr_ptr, read pointer rd_ptr and occupancy count.
- Pointers increment modulo DEPTH: DEPTH-1 wraps to 0.
- push = fire_in, except a bypassed beat (see Configuration) is not pushed.
- pop = fire_out while count != 0.
- push & !pop: write data_in at wr_ptr, advance wr_ptr, count+1.
- pop & !push: advance rd_ptr, count-1.
- push & pop: write and read in the same cycle, advance both pointers, count unchanged. This is legal at any count, including count == DEPTH-1.
- ready_in = ready_in_r & !flush.
  - ready_in_r is a register loaded each cycle with (count_next < DEPTH).
  - When full, ready_in stays 0 in the cycle a pop occurs and rises the following cycle. This is the price of the registered ready.
- When count != 0: valid_out = !flush; data_out = mem[rd_ptr].
- flush = 1:
  - valid_out = 0 and ready_in = 0, so no transfers occur that cycle.
  - Next cycle: count = 0 and wr_ptr = rd_ptr = 0.
  - Array contents are left as-is.
- Overflow and underflow cannot occur by construction. The bench flags any push at count == DEPTH or any pop at count == 0 as an error.
- Once valid_out = 1 while ready_out = 0, data_out stays stable until fire_out. This holds for stored beats.

## Timing
- Reset (rstn low, asynchronous):
  - count = 0, wr_ptr = rd_ptr = 0, ready_in_r = 0, all array entries = 0.
  - Outputs: ready_in = 0, count = 0.
  - valid_out = 0 and data_out = 0 when bypass is compiled out.
  - valid_out = valid_in and data_out = data_in when bypass is compiled in.
- After reset release: ready_in rises at the first rising edge.
- Reset asserted mid-transfer: all stored beats are discarded immediately, with no partial update.
- Latency, bypass compiled out: a beat accepted at edge N is presented on valid_out in cycle N+1.
- Latency, bypass compiled in: zero cycles when count == 0.
- Throughput: one beat per cycle sustained in both directions whenever 0 < count < DEPTH.
- count reflects registered state only; it updates the cycle after each push or pop.

## Configuration
- Macro HS_FIFO_BUF_BYPASS_EN.
- Defined: while count == 0 and flush == 0, valid_out = valid_in and data_out = data_in combinationally.
  - If ready_out = 1 as well, the beat passes straight through and is not stored; count stays 0.
  - If ready_out = 0, the beat is pushed and presented from storage the next cycle.
- Not defined: no combinational path from any input to valid_out or data_out. Every beat is stored, and minimum latency is 1 cycle.

## Test plan
- Reset, then hold valid_in = 1 with data 0x1,0x2,… and ready_out = 1 -> bypass out: data_out sequence 0x1,0x2,… lags by exactly 1 cycle and count stays 1. Bypass in: same-cycle pass-through and count stays 0.
- DEPTH = 4, ready_out = 0, push 0xA0..0xA3 -> count = 4, ready_in = 0 the next cycle. A fifth valid_in is not accepted and valid_out holds 0xA0 stable.
- From full, one cycle of ready_out = 1 -> 0xA0 out, count = 3, ready_in = 0 in the pop cycle and 1 the cycle after.
- DEPTH = 3, random valid_in/ready_out for 10k cycles with incrementing data -> output is in order with no loss or duplication, pointers wrap 2 -> 0, and count never exceeds 3.
- Fill to 2 beats, assert flush with valid_in = ready_out = 1 -> no fire that cycle, count = 0 next cycle, then the next beat in is the next beat out.
- Assert rstn low asynchronously while count = 3 -> count = 0, ready_in = 0 immediately, and no stale data appears after release.
